// File: rtl/sram_bus_arb.sv
// Unified single-port, byte-writable RAM shared by CPU instruction and data ports.
// Data has fixed priority; a saturating starvation counter bounds instruction wait.
module sram_bus_arb #(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 16,
   parameter int ADDR_LSB     = 2,
   parameter int STARVE_LIMIT = 4,
   parameter int RANGE_CHK    = 1
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic                inst_req_i,
   input  logic [DATA_W/8-1:0] inst_wen_i,
   input  logic [31:0]         inst_addr_i,
   input  logic [DATA_W-1:0]   inst_wdata_i,
   output logic                inst_ready_o,
   output logic                inst_rvalid_o,
   output logic [DATA_W-1:0]   inst_rdata_o,
   output logic                inst_err_o,
   input  logic                data_req_i,
   input  logic [DATA_W/8-1:0] data_wen_i,
   input  logic [31:0]         data_addr_i,
   input  logic [DATA_W-1:0]   data_wdata_i,
   output logic                data_ready_o,
   output logic                data_rvalid_o,
   output logic [DATA_W-1:0]   data_rdata_o,
   output logic                data_err_o
);

   localparam int         NB    = DATA_W / 8;
   localparam int         DEPTH = 2 ** ADDR_W;
   localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

   logic [7:0]        starve_q, starve_d;
   logic              inst_gnt, data_gnt;
   logic              acc_vld, acc_rd, acc_oor;
   logic [31:0]       acc_addr, acc_word;
   logic [NB-1:0]     acc_wen;
   logic [DATA_W-1:0] acc_wdata;
   logic [ADDR_W-1:0] acc_idx;

   logic              inst_rvalid_q, data_rvalid_q;
   logic              inst_err_q, data_err_q;
   logic              rd_oor_q;
   logic [DATA_W-1:0] inst_hold_q, data_hold_q;
   logic [DATA_W-1:0] ram_rdata, rd_now;

   // Grant: data wins unless the instruction side has waited STARVE_LIMIT cycles.
   always_comb begin
      inst_gnt = 1'b0;
      data_gnt = 1'b0;
      if (!reset_i) begin
         if (inst_req_i && (!data_req_i || starve_q == LIMIT)) begin
            inst_gnt = 1'b1;
         end else if (data_req_i) begin
            data_gnt = 1'b1;
         end
      end
   end

   always_comb begin
      starve_d = starve_q;
      if (!inst_req_i || inst_gnt) begin
         starve_d = 8'd0;
      end else if (starve_q < LIMIT) begin
         starve_d = starve_q + 8'd1;
      end
   end

   always_comb begin
      acc_addr  = data_addr_i;
      acc_wen   = data_wen_i;
      acc_wdata = data_wdata_i;
      if (inst_gnt) begin
         acc_addr  = inst_addr_i;
         acc_wen   = inst_wen_i;
         acc_wdata = inst_wdata_i;
      end
   end

   assign acc_vld  = inst_gnt | data_gnt;
   assign acc_rd   = acc_vld && (acc_wen == '0);
   assign acc_word = acc_addr >> ADDR_LSB;
   assign acc_idx  = acc_word[ADDR_W-1:0];
   assign acc_oor  = (RANGE_CHK != 0) && ((acc_word >> ADDR_W) != 32'h0);

   // One 8-bit RAM per byte lane so each lane infers its own write enable.
   for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] rd_q;
      always_ff @(posedge clk_i) begin
         if (acc_vld && !acc_oor && acc_wen[gi]) begin
            mem[acc_idx] <= acc_wdata[gi*8 +: 8];
         end
         if (acc_rd && !acc_oor) begin
            rd_q <= mem[acc_idx];
         end
      end
      assign ram_rdata[gi*8 +: 8] = rd_q;
   end

   assign rd_now = rd_oor_q ? '0 : ram_rdata;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         starve_q      <= 8'd0;
         inst_rvalid_q <= 1'b0;
         data_rvalid_q <= 1'b0;
         inst_err_q    <= 1'b0;
         data_err_q    <= 1'b0;
         rd_oor_q      <= 1'b0;
         inst_hold_q   <= '0;
         data_hold_q   <= '0;
      end else begin
         starve_q      <= starve_d;
         inst_rvalid_q <= inst_gnt && acc_rd;
         data_rvalid_q <= data_gnt && acc_rd;
         inst_err_q    <= inst_gnt && acc_oor;
         data_err_q    <= data_gnt && acc_oor;
         if (acc_rd) begin
            rd_oor_q <= acc_oor;
         end
         if (inst_rvalid_q) begin
            inst_hold_q <= rd_now;
         end
         if (data_rvalid_q) begin
            data_hold_q <= rd_now;
         end
      end
   end

   // Gating with reset discards a read whose result would land during reset.
   assign inst_ready_o  = inst_gnt;
   assign data_ready_o  = data_gnt;
   assign inst_rvalid_o = inst_rvalid_q && !reset_i;
   assign data_rvalid_o = data_rvalid_q && !reset_i;
   assign inst_err_o    = inst_err_q && !reset_i;
   assign data_err_o    = data_err_q && !reset_i;
   assign inst_rdata_o  = inst_rvalid_o ? rd_now : inst_hold_q;
   assign data_rdata_o  = data_rvalid_o ? rd_now : data_hold_q;

endmodule

// File: doc/sram_bus_arb.md
# sram_bus_arb

Parametrised shared-memory arbiter: one single-port, byte-writable synchronous RAM serving both CPU instruction and data ports through a req/ready/rvalid handshake. Replaces the fixed split instruction/data RAMs in the SoC top whenever a unified memory of configurable width and depth is needed. Data has fixed priority; a starvation guard bounds instruction-side wait. Adds out-of-range detection absent from the fixed RAMs.

## Interface
- DATA_W, 32, data width in bits; multiple of 8
- ADDR_W, 16, word-address bits; RAM depth = 2^ADDR_W words
- ADDR_LSB, 2, byte-offset bits dropped from the byte address (log2(DATA_W/8))
- STARVE_LIMIT, 4, instruction-wait cycles after which instruction wins; 1..255
- RANGE_CHK, 1, 1 = flag addresses with nonzero bits above ADDR_LSB+ADDR_W; 0 = alias silently
- clk  in  1  clock; all logic on posedge
- reset  in  1  synchronous, active-high
- inst_req / data_req  in  1  request valid, per port
- inst_wen / data_wen  in  DATA_W/8  byte write enables; 0 = read
- inst_addr / data_addr  in  32  byte address
- inst_wdata / data_wdata  in  DATA_W  write data
- inst_ready / data_ready  out  1  request accepted this cycle (grant)
- inst_rvalid / data_rvalid  out  1  read data valid this cycle
- inst_rdata / data_rdata  out  DATA_W  read data
- inst_err / data_err  out  1  out-of-range flag, qualified by rvalid (reads) or one-cycle pulse (writes)

## Operation
- Request transfers when req && ready in same cycle. Requester holds req, wen, addr, wdata stable until ready.
- Grant (combinational from req and starve counter): data only -> data; inst only -> inst; both -> data unless starve_cnt == STARVE_LIMIT, then inst. At most one ready per cycle.
- starve_cnt (8 bits): +1 each cycle inst_req && !inst_ready; cleared on inst grant or inst_req low; saturates at STARVE_LIMIT.
- Granted write: byte lanes with wen[i]=1 update RAM word addr[ADDR_LSB+:ADDR_W]; other lanes unchanged; no rvalid.
- Granted read (wen==0): RAM read, rdata and rvalid for that port next cycle.
- Out of range (RANGE_CHK=1, addr[31:ADDR_LSB+ADDR_W] != 0): access accepted (ready=1) but RAM not touched; read -> rvalid=1, rdata=0, err=1 next cycle; write -> err=1 next cycle, no rvalid. RANGE_CHK=0: upper bits ignored (wrap-around aliasing), err tied 0.
- rdata holds last read value between rvalids; valid only when rvalid.
- RAM contents not cleared by reset; simulation initial contents undefined.

## Timing
- Reset values: ready 0 while reset high; rvalid 0, err 0, rdata 0, starve_cnt 0.
- Read latency: grant at cycle T -> rvalid/rdata at T+1. Back-to-back grants sustain one access per cycle.
- Write at T, read same word granted at T+1 -> returns written data (RAM updated at end of T).
- Read and write never coincide (single port); no read-during-write case.
- Reset asserted while a read is in flight (grant at T, reset at T+1): rvalid stays 0; result discarded.
- Worst-case inst latency under continuous data_req: STARVE_LIMIT cycles wait, grant on cycle STARVE_LIMIT+1.

## Test plan
- Reset, then inst_req read addr 0x0 (pre-written 0x1234_5678) -> inst_ready same cycle, inst_rvalid next cycle with rdata 0x1234_5678, all outputs 0 during reset.
- data write 0x0000_0010 wen=4'b0011 wdata 0xAABB_CCDD over word 0x1111_1111, then read -> 0x1111_CCDD one cycle after read grant.
- Both ports request every cycle, STARVE_LIMIT=4 -> data granted 4 cycles, inst granted cycle 5, counter back to 0, pattern repeats.
- Continuous data reads to consecutive addresses -> rvalid high every cycle, rdata matching pre-loaded pattern, one cycle behind grants.
- RANGE_CHK=1, ADDR_W=16: read 0x0004_0000 -> rvalid=1, rdata=0, err=1; write to same -> err pulse, RAM word 0 unchanged. RANGE_CHK=0: same write aliases to word 0.
- Read granted at T, reset high at T+1 -> no rvalid; after release, starve_cnt 0 and first request served normally.
